// File: rtl/sq_meter_pkg.sv
// Shared types and helpers for the square-wave period meter.
package sq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  // Saturation value of a counter w bits wide.
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history
// flop for single-cycle rise/fall detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_det,
  output logic fall_det
);

  // Fewer than two stages would not give metastability time to settle.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              sync_lvl;

  assign sync_lvl = sync_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_lvl;
    end
  end

  assign rise_det = sync_lvl & ~hist_q;
  assign fall_det = ~sync_lvl & hist_q;

endmodule

// File: rtl/sq_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk25
// cycles and delivers each result over a valid/ready interface.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled; counter held at 0
// ARM     | waiting for the first rising edge to start counting
// MEASURE | counting; each rising edge closes a period and restarts
module sq_period_meter
  import sq_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_reg_q;
  logic             hi_cap_done_q;
  logic             rise_det, fall_det;

  logic cnt_clear, cnt_start, cnt_inc;
  logic hi_capture, result_fire, timeout_hit;
  logic accept, load, drop;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk25),
    .rst      (rst),
    .din      (sig_in),
    .rise_det (rise_det),
    .fall_det (fall_det)
  );

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise_det) state_d = MEASURE;
        MEASURE: if (!rise_det && cnt_q == CNT_MAX) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // A disable cycle suppresses any result so partial periods never escape.
  always_comb begin
    cnt_clear   = 1'b0;
    cnt_start   = 1'b0;
    cnt_inc     = 1'b0;
    hi_capture  = 1'b0;
    result_fire = 1'b0;
    timeout_hit = 1'b0;
    if (!enable) begin
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: cnt_clear = 1'b1;
        ARM:  cnt_start = rise_det;
        MEASURE: begin
          if (rise_det) begin
            result_fire = 1'b1;
            cnt_start   = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            timeout_hit = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
          hi_capture = fall_det & ~hi_cap_done_q;
        end
        default: cnt_clear = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      hi_reg_q      <= '0;
      hi_cap_done_q <= 1'b0;
    end else begin
      if (cnt_clear)      cnt_q <= '0;
      else if (cnt_start) cnt_q <= CNT_W'(1);
      else if (cnt_inc)   cnt_q <= cnt_q + CNT_W'(1);

      if (cnt_start)       hi_cap_done_q <= 1'b0;
      else if (hi_capture) hi_cap_done_q <= 1'b1;

      if (hi_capture) hi_reg_q <= cnt_q;
    end
  end

  assign accept = meas_valid & meas_ready;
  assign load   = result_fire & (~meas_valid | meas_ready);
  assign drop   = result_fire & meas_valid & ~meas_ready;

  // New events win over the clear-on-accept of the sticky flags.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      meas_valid <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        meas_valid <= 1'b1;
        period_cnt <= cnt_q;
        high_cnt   <= hi_reg_q;
      end else if (accept) begin
        meas_valid <= 1'b0;
      end

      if (timeout_hit) timeout <= 1'b1;
      else if (accept) timeout <= 1'b0;

      if (drop)        overrun <= 1'b1;
      else if (accept) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sq_period_meter.sv
// Directed bench for sq_period_meter: square-wave generator plus per-feature tasks.
`timescale 1ns/1ps
module tb_sq_period_meter;
  import sq_meter_pkg::*;

  localparam int CNT_W = 8;

  logic             clk25 = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             sig_in;
  logic             meas_ready = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             timeout;
  logic             overrun;

  int total = 0;
  int bad = 0;

  bit gen_on = 1'b0;
  int gen_period = 400;
  int gen_high = 160;
  int gen_jit = 0;
  int rise_cnt = 0;

  sq_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk25      (clk25),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #20 clk25 = ~clk25;

  // Edges sit 10 ns (rise) and high+10 ns (fall) after a clk25 rising edge, +/- jitter.
  initial begin : gen
    int jr, jf;
    sig_in = 1'b0;
    forever begin
      if (!gen_on) begin
        sig_in = 1'b0;
        wait (gen_on);
        @(posedge clk25);
      end
      jr = int'($urandom_range(0, 2 * gen_jit)) - gen_jit;
      jf = int'($urandom_range(0, 2 * gen_jit)) - gen_jit;
      #(10 + jr);
      sig_in = 1'b1;
      rise_cnt++;
      #(gen_high + jf - jr);
      sig_in = 1'b0;
      #(gen_period - gen_high - jf - 10);
    end
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk25);
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_gen();
    gen_on = 1'b0;
    repeat (30) @(negedge clk25);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    meas_ready = 1'b0;
    repeat (3) @(negedge clk25);
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", meas_valid); end
    total++; if (period_cnt !== '0) begin bad++; $display("FAIL reset_period got=%0d want=0", period_cnt); end
    total++; if (high_cnt !== '0) begin bad++; $display("FAIL reset_high got=%0d want=0", high_cnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int r0, pulses;
    bit vals_ok;
    enable = 1'b1;
    meas_ready = 1'b1;
    @(negedge clk25);
    r0 = rise_cnt;
    gen_on = 1'b1;
    wait_valid(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_first_valid got=timeout want=valid"); end
    total++; if (rise_cnt - r0 !== 2) begin bad++; $display("FAIL basic_rises_before_valid got=%0d want=2", rise_cnt - r0); end
    total++; if (period_cnt !== 8'd10) begin bad++; $display("FAIL basic_period got=%0d want=10", period_cnt); end
    total++; if (high_cnt !== 8'd4) begin bad++; $display("FAIL basic_high got=%0d want=4", high_cnt); end
    pulses = 0;
    vals_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk25);
      if (meas_valid) begin
        pulses++;
        if (period_cnt !== 8'd10 || high_cnt !== 8'd4) vals_ok = 1'b0;
      end
    end
    total++; if (pulses !== 5) begin bad++; $display("FAIL basic_rate got=%0d want=5", pulses); end
    total++; if (!vals_ok) begin bad++; $display("FAIL basic_repeat_values got=bad want=10/4"); end
    total++; if (timeout !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b want=00", timeout, overrun); end
  endtask

  task automatic test_overrun();
    bit ok, stable;
    logic [CNT_W-1:0] p0, h0;
    meas_ready = 1'b0;
    wait_valid(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_valid got=timeout want=valid"); end
    p0 = period_cnt;
    h0 = high_cnt;
    total++; if (p0 !== 8'd10 || h0 !== 8'd4) begin bad++; $display("FAIL ovr_first got=%0d/%0d want=10/4", p0, h0); end
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk25);
      if (meas_valid !== 1'b1 || period_cnt !== p0 || high_cnt !== h0) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL ovr_hold got=changed want=stable"); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", overrun); end
    meas_ready = 1'b1;
    @(negedge clk25);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    wait_valid(20, ok);
    total++; if (!ok || period_cnt !== 8'd10 || high_cnt !== 8'd4) begin bad++; $display("FAIL ovr_next got=%0d/%0d want=10/4", period_cnt, high_cnt); end
  endtask

  task automatic test_enable();
    bit ok;
    int r0;
    wait_valid(20, ok);
    repeat (3) @(negedge clk25);
    enable = 1'b0;
    repeat (10) @(negedge clk25);
    enable = 1'b1;
    r0 = rise_cnt;
    wait_valid(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_valid got=timeout want=valid"); end
    total++; if (rise_cnt - r0 !== 2) begin bad++; $display("FAIL en_fresh_rises got=%0d want=2", rise_cnt - r0); end
    total++; if (period_cnt !== 8'd10 || high_cnt !== 8'd4) begin bad++; $display("FAIL en_values got=%0d/%0d want=10/4", period_cnt, high_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0;
    wait_valid(20, ok);
    #5;
    rst = 1'b1;
    #1;
    total++; if (meas_valid !== 1'b0 || period_cnt !== '0 || high_cnt !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%0d/%0d want=0/0/0", meas_valid, period_cnt, high_cnt);
    end
    total++; if (timeout !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b%b want=00", timeout, overrun); end
    repeat (3) @(negedge clk25);
    rst = 1'b0;
    r0 = rise_cnt;
    wait_valid(40, ok);
    total++; if (!ok || rise_cnt - r0 !== 2) begin bad++; $display("FAIL rstmid_restart got=%0d rises want=2", rise_cnt - r0); end
    total++; if (period_cnt !== 8'd10 || high_cnt !== 8'd4) begin bad++; $display("FAIL rstmid_values got=%0d/%0d want=10/4", period_cnt, high_cnt); end
  endtask

  task automatic test_timeout();
    bit ok, seen_valid;
    int r0;
    stop_gen();
    rst = 1'b1;
    @(negedge clk25);
    rst = 1'b0;
    enable = 1'b1;
    meas_ready = 1'b1;
    @(negedge clk25);
    r0 = rise_cnt;
    gen_on = 1'b1;
    for (int i = 0; i < 10 && rise_cnt == r0; i++) @(negedge clk25);
    gen_on = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 245; i++) begin
      @(negedge clk25);
      if (meas_valid) seen_valid = 1'b1;
    end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", timeout); end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk25);
      if (meas_valid) seen_valid = 1'b1;
      if (timeout) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL to_flag got=0 want=1"); end
    total++; if (dut.state_q !== ARM) begin bad++; $display("FAIL to_state got=%0d want=%0d", dut.state_q, ARM); end
    total++; if (seen_valid) begin bad++; $display("FAIL to_no_result got=valid want=none"); end
    repeat (5) @(negedge clk25);
    r0 = rise_cnt;
    gen_on = 1'b1;
    wait_valid(40, ok);
    total++; if (!ok || rise_cnt - r0 !== 2) begin bad++; $display("FAIL to_recover got=%0d rises want=2", rise_cnt - r0); end
    total++; if (period_cnt !== 8'd10 || high_cnt !== 8'd4) begin bad++; $display("FAIL to_values got=%0d/%0d want=10/4", period_cnt, high_cnt); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", timeout); end
    @(negedge clk25);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", timeout); end
  endtask

  task automatic test_jitter();
    bit ok;
    stop_gen();
    gen_period = 1000;
    gen_high = 500;
    gen_jit = 3;
    rst = 1'b1;
    @(negedge clk25);
    rst = 1'b0;
    gen_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(80, ok);
      total++; if (!ok || period_cnt < 8'd24 || period_cnt > 8'd26) begin bad++; $display("FAIL jit_period[%0d] got=%0d want=24..26", k, period_cnt); end
      total++; if (high_cnt < 8'd12 || high_cnt > 8'd14) begin bad++; $display("FAIL jit_high[%0d] got=%0d want=12..14", k, high_cnt); end
    end
    gen_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_timeout();
    test_jitter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
